// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI register-access controller.
package ulpi_pkg;

  localparam int unsigned ULPI_ADDR_W = 6;

  // TX CMD prefixes for immediate register write / read
  localparam logic [1:0] ULPI_REGW = 2'b10;
  localparam logic [1:0] ULPI_REGR = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StWdata,
    StStp,
    StRturn,
    StRdata,
    StRwait,
    StAbort,
    StDone
  } ulpi_reg_state_e;

  // Build the TX CMD byte for an immediate register access
  function automatic logic [7:0] tx_cmd(input logic we, input logic [ULPI_ADDR_W-1:0] addr);
    return {(we ? ULPI_REGW : ULPI_REGR), addr};
  endfunction

endpackage

// File: rtl/ulpi_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted port.
module ulpi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic ptr_q;

  // Winner selection: on a tie the port that was not granted last wins
  always_comb begin
    gnt_any = |req;
    if (&req) begin
      gnt_idx = ~ptr_q;
    end else begin
      gnt_idx = req[1];
    end
  end

  // Pointer update on an accepted grant; reset to 1 so port 0 goes first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b1;
    end else if (take && gnt_any) begin
      ptr_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI register-access controller: arbitrates two requesters and sequences
// register write/read transactions with turnaround, PHY preemption, retry and timeout.
// TIMEOUT must be at least 1.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_we_i,
  input  logic [11:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic [1:0]  rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  input  logic [7:0]  data_i,
  input  logic        dir_i,
  input  logic        nxt_i,
  output logic [7:0]  data_o,
  output logic        stp_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT);
  // Expiry is flagged on the edge at which the timer reaches TIMEOUT
  localparam logic [TimerW-1:0] TimerHit = TimerW'(TIMEOUT - 1);

  ulpi_reg_state_e state_q, state_d;

  logic                   port_q, port_d;
  logic                   we_q, we_d;
  logic [ULPI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic                   err_q, err_d;
  logic                   gap_q, gap_d;
  logic [7:0]             rbuf_q, rbuf_d;

  logic [7:0] data_q, data_d;
  logic       stp_q, stp_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;
  logic       busy_q, busy_d;

  logic take;
  logic gnt_idx;
  logic gnt_any;
  logic expired;
  logic finish;
  logic finish_err;

  ulpi_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_i),
    .take    (take),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign expired = (timer_q >= TimerHit);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    timer_d     = timer_q;
    err_d       = err_q;
    gap_d       = 1'b0;
    rbuf_d      = rbuf_q;
    data_d      = 8'h00;
    stp_d       = 1'b0;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    take        = 1'b0;
    finish      = 1'b0;
    finish_err  = 1'b0;

    if (state_q != StIdle && timer_q != TimerMax) begin
      timer_d = timer_q + TimerW'(1);
    end

    unique case (state_q)
      StIdle: begin
        // The rsp_valid term keeps a just-completed request from being re-granted
        if (!dir_i && gnt_any && (rsp_valid_q == 2'b00)) begin
          take    = 1'b1;
          port_d  = gnt_idx;
          we_d    = req_we_i[gnt_idx];
          addr_d  = gnt_idx ? req_addr_i[11:6] : req_addr_i[5:0];
          wdata_d = gnt_idx ? req_wdata_i[15:8] : req_wdata_i[7:0];
          timer_d = '0;
          err_d   = 1'b0;
          state_d = StCmd;
          data_d  = tx_cmd(req_we_i[gnt_idx],
                           gnt_idx ? req_addr_i[11:6] : req_addr_i[5:0]);
        end
      end
      StCmd: begin
        if (expired) begin
          err_d   = 1'b1;
          stp_d   = 1'b1;
          state_d = StStp;
        end else if (dir_i) begin
          state_d = StAbort;
        end else if (nxt_i) begin
          if (we_q) begin
            state_d = StWdata;
            data_d  = wdata_q;
          end else begin
            state_d = StRturn;
          end
        end else begin
          data_d = tx_cmd(we_q, addr_q);
        end
      end
      StWdata: begin
        if (expired) begin
          err_d   = 1'b1;
          stp_d   = 1'b1;
          state_d = StStp;
        end else if (nxt_i) begin
          stp_d   = 1'b1;
          state_d = StStp;
        end else begin
          data_d = wdata_q;
        end
      end
      StStp: begin
        finish     = 1'b1;
        finish_err = err_q;
      end
      StRturn: begin
        if (expired) begin
          finish     = !dir_i;
          finish_err = 1'b1;
        end else if (dir_i) begin
          state_d = StRdata;
        end else begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      StRdata: begin
        if (expired) begin
          finish     = !dir_i;
          finish_err = 1'b1;
        end else if (nxt_i) begin
          state_d = StAbort;
        end else if (dir_i) begin
          rbuf_d  = data_i;
          state_d = StRwait;
        end else begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      StRwait: begin
        // gap_q marks the extra cycle after the PHY released the bus
        if (gap_q || (expired && !dir_i)) begin
          finish     = 1'b1;
          finish_err = expired;
        end else if (!dir_i) begin
          gap_d = 1'b1;
        end
      end
      StAbort: begin
        if (expired) begin
          finish     = !dir_i;
          finish_err = 1'b1;
        end else if (gap_q) begin
          state_d = StCmd;
          data_d  = tx_cmd(we_q, addr_q);
        end else if (!dir_i) begin
          gap_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (finish) begin
      state_d     = StDone;
      rsp_valid_d = port_q ? 2'b10 : 2'b01;
      rsp_err_d   = finish_err;
      if (!we_q && !finish_err) begin
        rsp_rdata_d = rbuf_q;
      end
    end

    busy_d = (state_d != StIdle);
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      timer_q     <= '0;
      err_q       <= 1'b0;
      gap_q       <= 1'b0;
      rbuf_q      <= 8'h00;
      data_q      <= 8'h00;
      stp_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      gap_q       <= gap_d;
      rbuf_q      <= rbuf_d;
      data_q      <= data_d;
      stp_q       <= stp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign stp_o       = stp_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl with hand-computed expectations.
module tb_ulpi_reg_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [1:0]  req_we_i;
  logic [11:0] req_addr_i;
  logic [15:0] req_wdata_i;
  logic [1:0]  rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic [7:0]  data_i;
  logic        dir_i;
  logic        nxt_i;
  logic [7:0]  data_o;
  logic        stp_o;

  int n_checks = 0;
  int n_pass   = 0;

  ulpi_reg_ctrl #(
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .data_i      (data_i),
    .dir_i       (dir_i),
    .nxt_i       (nxt_i),
    .data_o      (data_o),
    .stp_o       (stp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst         = 1'b0;
    req_i       = 2'b00;
    req_we_i    = 2'b00;
    req_addr_i  = 12'h000;
    req_wdata_i = 16'h0000;
    data_i      = 8'h00;
    dir_i       = 1'b0;
    nxt_i       = 1'b0;
    #1;
    check("rst_data", 16'(data_o), 16'h00);
    check("rst_stp", 16'(stp_o), 16'h0);
    check("rst_valid", 16'(rsp_valid_o), 16'h0);
    check("rst_rdata", 16'(rsp_rdata_o), 16'h00);
    check("rst_err", 16'(rsp_err_o), 16'h0);
    check("rst_busy", 16'(busy_o), 16'h0);
    #10 rst = 1'b1;
    tick();

    // Port 0 write 0x0A <= 0x55, zero-wait PHY
    req_i = 2'b01; req_we_i = 2'b01; req_addr_i = 12'h00A; req_wdata_i = 16'h0055;
    nxt_i = 1'b1;
    tick();
    check("w_cmd", 16'(data_o), 16'h8A);
    check("w_busy", 16'(busy_o), 16'h1);
    tick();
    check("w_wdata", 16'(data_o), 16'h55);
    tick();
    check("w_stp", 16'(stp_o), 16'h1);
    check("w_stp_data", 16'(data_o), 16'h00);
    tick();
    check("w_valid", 16'(rsp_valid_o), 16'h1);
    check("w_err", 16'(rsp_err_o), 16'h0);
    check("w_stp_low", 16'(stp_o), 16'h0);
    req_i = 2'b00; nxt_i = 1'b0;
    tick();
    check("w_valid_drop", 16'(rsp_valid_o), 16'h0);
    check("w_idle", 16'(busy_o), 16'h0);

    // Port 1 read 0x16, PHY returns 0xC3 after turnaround
    req_i = 2'b10; req_we_i = 2'b00; req_addr_i = 12'h580; nxt_i = 1'b1;
    tick();
    check("r_cmd", 16'(data_o), 16'hD6);
    tick();
    check("r_turn_data", 16'(data_o), 16'h00);
    nxt_i = 1'b0; dir_i = 1'b1;
    tick();
    data_i = 8'hC3;
    tick();
    check("r_not_early", 16'(rsp_valid_o), 16'h0);
    dir_i = 1'b0; data_i = 8'h00;
    tick();
    check("r_gap", 16'(rsp_valid_o), 16'h0);
    tick();
    check("r_valid", 16'(rsp_valid_o), 16'h2);
    check("r_rdata", 16'(rsp_rdata_o), 16'hC3);
    check("r_err", 16'(rsp_err_o), 16'h0);
    req_i = 2'b00;
    tick();

    // Simultaneous writes after reset: port 0 then port 1
    rst = 1'b0;
    #1;
    check("rst2_rdata", 16'(rsp_rdata_o), 16'h00);
    rst = 1'b1;
    req_i = 2'b11; req_we_i = 2'b11; req_addr_i = 12'h081; req_wdata_i = 16'h2211;
    nxt_i = 1'b1;
    tick();
    check("rr_cmd0", 16'(data_o), 16'h81);
    tick();
    check("rr_wdata0", 16'(data_o), 16'h11);
    tick();
    tick();
    check("rr_valid0", 16'(rsp_valid_o), 16'h1);
    req_i = 2'b10;
    tick();
    check("rr_gap_busy", 16'(busy_o), 16'h0);
    check("rr_gap_data", 16'(data_o), 16'h00);
    tick();
    check("rr_cmd1", 16'(data_o), 16'h82);
    tick();
    check("rr_wdata1", 16'(data_o), 16'h22);
    tick();
    tick();
    check("rr_valid1", 16'(rsp_valid_o), 16'h2);
    req_i = 2'b00; nxt_i = 1'b0;
    tick();

    // PHY preempts during CMD for four cycles, then the CMD is retried
    req_i = 2'b01; req_we_i = 2'b01; req_addr_i = 12'h00A; req_wdata_i = 16'h0055;
    tick();
    check("p_cmd", 16'(data_o), 16'h8A);
    dir_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p_dir_data", 16'(data_o), 16'h00);
    end
    dir_i = 1'b0;
    tick();
    check("p_idle_data", 16'(data_o), 16'h00);
    check("p_idle_valid", 16'(rsp_valid_o), 16'h0);
    tick();
    check("p_recmd", 16'(data_o), 16'h8A);
    nxt_i = 1'b1;
    tick();
    check("p_wdata", 16'(data_o), 16'h55);
    tick();
    check("p_stp", 16'(stp_o), 16'h1);
    tick();
    check("p_valid", 16'(rsp_valid_o), 16'h1);
    check("p_err", 16'(rsp_err_o), 16'h0);
    req_i = 2'b00; nxt_i = 1'b0;
    tick();

    // Timeout: PHY never asserts nxt
    req_i = 2'b10; req_we_i = 2'b10; req_addr_i = 12'h140; req_wdata_i = 16'h7700;
    tick();
    check("t_cmd", 16'(data_o), 16'h85);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("t_hold", {7'h0, stp_o, data_o}, 16'h0085);
    end
    tick();
    check("t_stp", 16'(stp_o), 16'h1);
    check("t_stp_data", 16'(data_o), 16'h00);
    tick();
    check("t_valid", 16'(rsp_valid_o), 16'h2);
    check("t_err", 16'(rsp_err_o), 16'h1);
    req_i = 2'b00;
    tick();

    // Reset during WDATA, then a normal write
    req_i = 2'b01; req_we_i = 2'b01; req_addr_i = 12'h00A; req_wdata_i = 16'h0055;
    nxt_i = 1'b1;
    tick();
    tick();
    check("x_wdata", 16'(data_o), 16'h55);
    #2 rst = 1'b0;
    #1;
    check("x_data", 16'(data_o), 16'h00);
    check("x_stp", 16'(stp_o), 16'h0);
    check("x_busy", 16'(busy_o), 16'h0);
    check("x_err", 16'(rsp_err_o), 16'h0);
    #1 rst = 1'b1;
    tick();
    check("x_cmd", 16'(data_o), 16'h8A);
    tick();
    check("x_wdata2", 16'(data_o), 16'h55);
    tick();
    check("x_stp2", 16'(stp_o), 16'h1);
    tick();
    check("x_valid", 16'(rsp_valid_o), 16'h1);
    check("x_err2", 16'(rsp_err_o), 16'h0);
    req_i = 2'b00; nxt_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_ctrl.md
# ulpi_reg_ctrl

ULPI PHY register-access controller that shares the link side of the ULPI bus between two register requesters: port 0 is PHY init/config and port 1 is runtime debug/status. It arbitrates round-robin and sequences ULPI register-write and register-read transactions, including turnaround, PHY preemption via `dir`, retry and timeout. It sits beside `usb_host` in the `usb_clk` domain; the top-level mux gives it `data_o`/`stp_o` while `busy_o` is high.

## Interface
- `TIMEOUT`, default 255: max cycles from grant to completion before the transaction is aborted with error.
- `clk` in 1: ULPI 60 MHz clock (`usb_clk` at top level).
- `rst` in 1: asynchronous, active-low reset.
- `req_i` in 2: per-port request, held high with fields stable until that port's `rsp_valid_o` bit.
- `req_we_i` in 2: per port, 1 = write, 0 = read.
- `req_addr_i` in 12: port n at bits [6n+5:6n]; 6-bit immediate register address.
- `req_wdata_i` in 16: port n at bits [8n+7:8n].
- `rsp_valid_o` out 2: one-cycle completion pulse to the granted port.
- `rsp_rdata_o` out 8: read data; valid with `rsp_valid_o`; holds until next completion.
- `rsp_err_o` out 1: timeout or protocol error; valid with `rsp_valid_o`.
- `busy_o` out 1: controller owns the link side, from grant through DONE.
- `data_i` in 8, `dir_i` in 1, `nxt_i` in 1: ULPI from PHY.
- `data_o` out 8, `stp_o` out 1: ULPI to PHY; all outputs registered.

## Operation
- States: IDLE, CMD, WDATA, STP, RTURN, RDATA, RWAIT, ABORT, DONE.
- IDLE:
  - Grant only when `dir_i`=0, some `req_i` is set, and `rsp_valid_o` is 0 this cycle (one-cycle gap prevents re-granting a stale request).
  - Latch the port's we/addr/wdata, clear the timer, go to CMD.
- Round-robin: the pointer holds the last granted port; the other port wins ties. Reset pointer = 1, so port 0 wins first.
- CMD:
  - `data_o` = {2'b10, addr} for write or {2'b11, addr} for read.
  - Hold until `nxt_i`=1 with `dir_i`=0. Then write goes to WDATA, read goes to RTURN (`data_o`←0).
  - `dir_i`=1 before `nxt_i`: PHY preempted, so `data_o`←0 and go to ABORT.
- WDATA: `data_o`=wdata; hold until `nxt_i`=1, then go to STP.
- STP: `stp_o`=1, `data_o`=0 for exactly one cycle, then DONE.
- RTURN: one turnaround cycle. `dir_i` must be 1, else error→DONE. Then RDATA.
- RDATA:
  - `dir_i`=1 and `nxt_i`=0: capture `data_i` into `rsp_rdata_o`, go to RWAIT.
  - `nxt_i`=1 (RX CMD preemption): ABORT.
  - `dir_i`=0: error→DONE.
- RWAIT: wait for `dir_i`=0, then one further cycle, then DONE.
- ABORT: wait for `dir_i`=0, then one idle cycle, then retry CMD with the same latched request. Retries are unlimited and bounded only by the timer.
- DONE: pulse `rsp_valid_o[port]` with `rsp_err_o`, then return to IDLE.
- Timer:
  - Width $clog2(TIMEOUT+1); increments every non-IDLE cycle and saturates.
  - Reaching TIMEOUT in CMD or WDATA: STP cycle, then DONE with err=1.
  - Reaching TIMEOUT in any other state: DONE with err=1, after `dir_i`=0.
- A request dropped mid-transaction is ignored; the transaction completes.
- `data_o` is 0 whenever the link is not transmitting.

## Timing
- Reset values: `data_o`=0, `stp_o`=0, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `busy_o`=0, state IDLE, pointer 1, timer 0.
- Reset mid-transaction: outputs return to reset values immediately. No STP is issued.
- Write, zero-wait PHY (grant edge = cycle 0):
  - cycle 1 CMD, cycle 2 WDATA, cycle 3 STP, cycle 4 `rsp_valid_o`.
- Read, zero-wait PHY:
  - cycle 1 CMD (`nxt` high), cycle 2 RTURN, cycle 3 RDATA captured, cycle 4 RWAIT (`dir` low).
  - cycle 5 extra cycle, cycle 6 `rsp_valid_o`.
- Next grant is no earlier than one cycle after the `rsp_valid_o` pulse.
- Simultaneous requests at reset: port 0 first, port 1 next.

## Structure
- Package `ulpi_pkg`:
  - state enum `ulpi_reg_state_e`;
  - TX CMD prefixes `ULPI_REGW`=2'b10 and `ULPI_REGR`=2'b11;
  - `ULPI_ADDR_W`=6.
- Sub-module `ulpi_rr_arb2`: 2-way round-robin arbiter with pointer update on grant.

## Test plan
- Port 0 write addr 0x0A, data 0x55; PHY `nxt` immediately → `data_o` 0x8A, then 0x55, then stp with 0x00; `rsp_valid_o`=01 at cycle 4, err=0.
- Port 1 read addr 0x16; PHY returns 0xC3 after turnaround → `data_o` 0xD6; `rsp_rdata_o`=0xC3; `rsp_valid_o`=10 at cycle 6.
- Both ports request writes together from reset → port 0 completes first, port 1 second, with one idle gap and no back-to-back re-grant to port 0.
- PHY raises `dir_i` during CMD for 4 cycles → `data_o`=0 while `dir_i`=1; CMD 0x8A re-issued after `dir_i` falls plus one idle cycle; completes err=0.
- With TIMEOUT=16, PHY never asserts `nxt_i` → STP cycle at timer 16, then `rsp_valid_o` with err=1.
- `rst` asserted during WDATA → `data_o`, `stp_o` and `busy_o` go to 0 asynchronously; next request after release proceeds normally.
